// File: rtl/xnor_popcount_accum_if.sv
// Beat/result handshake bundle between the XNOR-popcount stage, the accumulator
// and the next layer's input buffer.
interface xnor_popcount_accum_if #(
  parameter int POP_W = 9,
  parameter int ACC_W = 13
);
  logic                    pop_valid;
  logic [POP_W-1:0]        pop_in;
  logic                    pop_last;
  logic signed [ACC_W:0]   thresh;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_bit;
  logic signed [ACC_W:0]   out_dot;
  logic                    out_err;

  modport master (
    output pop_valid, pop_in, pop_last, thresh, out_ready,
    input  in_ready, out_valid, out_bit, out_dot, out_err
  );

  modport slave (
    input  pop_valid, pop_in, pop_last, thresh, out_ready,
    output in_ready, out_valid, out_bit, out_dot, out_err
  );
endinterface

// File: rtl/xnor_popcount_accum.sv
// Sums per-chunk popcounts for one neuron, converts the total to a signed
// binarized dot product and thresholds it into a single activation bit.
module xnor_popcount_accum #(
  parameter int CHUNK_BITS = 256,
  parameter int POP_W      = 9,
  parameter int MAX_CHUNKS = 16,
  parameter int CNT_W      = 5,
  parameter int ACC_W      = 13
) (
  input logic                 clk,
  input logic                 rst,
  xnor_popcount_accum_if.slave bus
);
  localparam int DOT_W       = ACC_W + 1;
  localparam int CHUNK_SHIFT = $clog2(CHUNK_BITS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic                     out_bit_q;
  logic signed [DOT_W-1:0]  out_dot_q;
  logic                     out_err_q;

  logic                     accept;
  logic                     terminate;
  logic [ACC_W-1:0]         acc_next;
  logic [CNT_W-1:0]         cnt_next;
  logic signed [DOT_W-1:0]  dot_next;

  assign accept    = (state == ACCUM) && bus.pop_valid;
  assign terminate = bus.pop_last || (cnt == CNT_W'(MAX_CHUNKS - 1));
  assign acc_next  = acc + {{(ACC_W-POP_W){1'b0}}, bus.pop_in};
  assign cnt_next  = cnt + CNT_W'(1);
  // 2*acc can exceed the signed range on its own, but the difference always
  // fits, so modular DOT_W-bit arithmetic yields the exact result.
  assign dot_next  = $signed({acc_next, 1'b0})
                   - $signed(DOT_W'(cnt_next) << CHUNK_SHIFT);

  // Handshake flags decode the state register only: no path from out_ready/pop_valid.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_bit   = out_bit_q;
  assign bus.out_dot   = out_dot_q;
  assign bus.out_err   = out_err_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // all state, including the result registers, is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_bit_q <= 1'b0;
      out_dot_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (terminate) begin
              out_dot_q <= dot_next;
              out_bit_q <= (dot_next >= $signed(bus.thresh));
              out_err_q <= ~bus.pop_last;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_xnor_popcount_accum.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized neuron stream checked against an arithmetic reference model.
module tb_xnor_popcount_accum;
  localparam int CHUNK_BITS = 256;
  localparam int MAX_CHUNKS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  xnor_popcount_accum_if #(.POP_W(9), .ACC_W(13)) bus ();

  xnor_popcount_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int    n;
    int    first_pop;
    int    rest_pop;
    int    thr;
    int    e_dot;
    bit    e_bit;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Presents one beat and holds it until accepted (bounded wait).
  task automatic send_beat(input int pop, input bit last, input int thr);
    int waited = 0;
    bus.pop_valid = 1'b1;
    bus.pop_in    = 9'(pop);
    bus.pop_last  = last;
    bus.thresh    = 14'(thr);
    while (!bus.in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    tick();
    bus.pop_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input int e_dot, input bit e_bit,
                            input bit e_err, input int stall);
    int waited = 0;
    while (!bus.out_valid && waited < 100) begin
      tick();
      waited++;
    end
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_dot"},   int'(bus.out_dot),   e_dot);
    check({name, "_bit"},   int'(bus.out_bit),   int'(e_bit));
    check({name, "_err"},   int'(bus.out_err),   int'(e_err));
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_in_ready_after"}, int'(bus.in_ready), 1);
  endtask

  task automatic run_neuron(input int n, input int first_pop, input int rest_pop,
                            input int thr);
    for (int i = 0; i < n; i++)
      send_beat((i == 0) ? first_pop : rest_pop, (i == n - 1), thr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"four_128_t0",   4, 128, 128,    0,    0, 1'b1};
    vecs[1] = '{"four_128_t1",   4, 128, 128,    1,    0, 1'b0};
    vecs[2] = '{"zero_ten",      2,   0,  10, -500, -492, 1'b1};
    vecs[3] = '{"single_256",    1, 256,   0, 4096,  256, 1'b0};
    vecs[4] = '{"three_mixed",   3, 256, 100,  144,  144, 1'b1};
    vecs[5] = '{"just_below",    2,   1,   0, -509, -510, 1'b0};

    bus.pop_valid = 1'b0;
    bus.pop_in    = '0;
    bus.pop_last  = 1'b0;
    bus.thresh    = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_dot",   int'(bus.out_dot),   0);
    check("rst_out_bit",   int'(bus.out_bit),   0);
    check("rst_out_err",   int'(bus.out_err),   0);

    // Reset mid-neuron discards the partial sum.
    for (int i = 0; i < 3; i++) send_beat(200, 1'b0, 0);
    pulse_reset();
    check("midrst_in_ready",  int'(bus.in_ready),  1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    send_beat(256, 1'b1, 0);
    get_result("midrst", 256, 1'b1, 1'b0, 0);

    for (int v = 0; v < 6; v++) begin
      run_neuron(vecs[v].n, vecs[v].first_pop, vecs[v].rest_pop, vecs[v].thr);
      get_result(vecs[v].name, vecs[v].e_dot, vecs[v].e_bit, 1'b0, v % 3);
    end

    // Reset during HOLD drops the pending result.
    run_neuron(2, 50, 50, 0);
    check("holdrst_valid_before", int'(bus.out_valid), 1);
    pulse_reset();
    check("holdrst_out_valid", int'(bus.out_valid), 0);
    check("holdrst_out_dot",   int'(bus.out_dot),   0);
    check("holdrst_in_ready",  int'(bus.in_ready),  1);

    // Chunk limit: 16 beats with no pop_last force termination.
    for (int i = 0; i < MAX_CHUNKS; i++) send_beat(256, 1'b0, 0);
    check("limit_out_valid", int'(bus.out_valid), 1);
    check("limit_out_dot",   int'(bus.out_dot),   4096);
    check("limit_out_err",   int'(bus.out_err),   1);
    check("limit_out_bit",   int'(bus.out_bit),   1);
    check("limit_in_ready",  int'(bus.in_ready),  0);
    bus.pop_valid = 1'b1;
    bus.pop_in    = 9'd5;
    bus.pop_last  = 1'b1;
    bus.thresh    = '0;
    repeat (3) tick();
    check("limit_17th_held_dot", int'(bus.out_dot),   4096);
    check("limit_17th_valid",    int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("limit_handoff_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.pop_valid = 1'b0;
    get_result("limit_17th_beat", 10 - CHUNK_BITS, 1'b0, 1'b0, 0);

    // Back-pressure: result held, in_ready low, pending beat not consumed.
    run_neuron(2, 100, 100, 0);
    bus.pop_valid = 1'b1;
    bus.pop_in    = 9'd7;
    bus.pop_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_in_ready",  int'(bus.in_ready),  0);
      check("bp_out_dot",   int'(bus.out_dot),   -112);
      check("bp_out_bit",   int'(bus.out_bit),   0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_handoff_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.pop_valid = 1'b0;
    send_beat(3, 1'b1, 0);
    get_result("bp_next", -492, 1'b0, 1'b0, 0);

    // Randomized neuron stream vs. arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      int n, sum, thr, pop, exp_dot;
      bit last_flag;
      n         = int'($urandom_range(1, MAX_CHUNKS));
      last_flag = (n < MAX_CHUNKS) ? 1'b1 : 1'($urandom_range(0, 1));
      thr       = int'($urandom_range(0, 8192)) - 4096;
      sum       = 0;
      for (int i = 0; i < n; i++) begin
        pop  = int'($urandom_range(0, CHUNK_BITS));
        sum += pop;
        send_beat(pop, (i == n - 1) ? last_flag : 1'b0,
                  (i == n - 1) ? thr : int'($urandom_range(0, 8192)) - 4096);
        if ($urandom_range(0, 3) == 0 && i != n - 1) repeat ($urandom_range(1, 2)) tick();
      end
      exp_dot = 2 * sum - CHUNK_BITS * n;
      get_result("rand", exp_dot, exp_dot >= thr, ~last_flag, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
